// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency RAM between NUM_PORTS requesters.
// Optional atomic lock support is compiled in with `define RAM_ARB_LOCK_EN.
module ram_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              req_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_PORTS-1:0]              lock_i,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              ram_en_o,
  output logic [ADDR_WIDTH-1:0]             ram_addr_o,
  output logic                              ram_we_o,
  output logic [DATA_WIDTH/8-1:0]           ram_be_o,
  output logic [DATA_WIDTH-1:0]             ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;

  logic [PW-1:0]        r_ptr;
  logic [NUM_PORTS-1:0] r_rvalid;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_next;
  logic                 w_any;
  int                   w_idx;

`ifdef RAM_ARB_LOCK_EN
  logic          r_locked;
  logic [PW-1:0] r_owner;
`else
  logic          w_unused_lock;
  assign w_unused_lock = ^lock_i;
`endif

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
      if (!w_any && req_i[w_idx]) begin
        w_any = 1'b1;
        w_win = PW'(w_idx);
      end
    end
`ifdef RAM_ARB_LOCK_EN
    // A held lock overrides the rotation only while its owner keeps requesting.
    if (r_locked && req_i[r_owner]) begin
      w_any = 1'b1;
      w_win = r_owner;
    end
`endif
  end

  assign w_next = (int'(w_win) == NUM_PORTS - 1) ? '0 : w_win + PW'(1);

  assign gnt_o       = w_any ? (NUM_PORTS'(1) << w_win) : '0;
  assign ram_en_o    = |req_i;
  assign ram_addr_o  = addr_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_we_o    = we_i[w_win];
  assign ram_be_o    = be_i[w_win*BW +: BW];
  assign ram_wdata_o = wdata_i[w_win*DATA_WIDTH +: DATA_WIDTH];
  assign rdata_o     = ram_rdata_i;
  assign rvalid_o    = r_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
`ifdef RAM_ARB_LOCK_EN
      r_locked <= 1'b0;
      r_owner  <= '0;
`endif
    end else begin
      r_rvalid <= gnt_o;
`ifdef RAM_ARB_LOCK_EN
      if (w_any) begin
        r_locked <= lock_i[w_win];
        if (lock_i[w_win]) r_owner <= w_win;
        else               r_ptr   <= w_next;
      end else begin
        r_locked <= 1'b0;
      end
`else
      if (w_any) r_ptr <= w_next;
`endif
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: directed literal checks plus randomized
// traffic compared every cycle against a behavioural round-robin model.
module tb_ram_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_i = '0;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    rvalid_o;
  logic [N*AW-1:0] addr_i = '0;
  logic [N-1:0]    we_i = '0;
  logic [N*BW-1:0] be_i = '0;
  logic [N*DW-1:0] wdata_i = '0;
  logic [N-1:0]    lock_i = '0;
  logic [DW-1:0]   rdata_o;
  logic            ram_en_o;
  logic [AW-1:0]   ram_addr_o;
  logic            ram_we_o;
  logic [BW-1:0]   ram_be_o;
  logic [DW-1:0]   ram_wdata_o;
  logic [DW-1:0]   ram_rdata_i = '0;

  int total = 0;
  int bad   = 0;

  ram_rr_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .lock_i(lock_i),
    .rdata_o(rdata_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer, lock state and expected response vector.
  int           m_ptr = 0;
  logic [N-1:0] m_rvalid = '0;
  logic         m_locked = 1'b0;
  int           m_owner = 0;

  function automatic int m_winner(input logic [N-1:0] req);
    if (m_locked && req[m_owner]) return m_owner;
    for (int i = 0; i < N; i++)
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr    <= 0;
      m_rvalid <= '0;
      m_locked <= 1'b0;
      m_owner  <= 0;
    end else begin
      int w;
      w = m_winner(req_i);
      m_rvalid <= (w >= 0) ? (N'(1) << w) : '0;
`ifdef RAM_ARB_LOCK_EN
      if (w >= 0) begin
        m_locked <= lock_i[w];
        if (lock_i[w]) m_owner <= w;
        else           m_ptr   <= (w + 1) % N;
      end else begin
        m_locked <= 1'b0;
      end
`else
      if (w >= 0) m_ptr <= (w + 1) % N;
`endif
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int w;
      w = m_winner(req_i);
      chk("mdl_gnt", gnt_o, (w >= 0) ? (N'(1) << w) : '0);
      chk("mdl_en", ram_en_o, |req_i);
      chk("mdl_rvalid", rvalid_o, m_rvalid);
      chk("mdl_rdata", rdata_o, ram_rdata_i);
      chk("mdl_ptr", dut.r_ptr, m_ptr);
      if (ram_en_o && w >= 0) begin
        chk("mdl_addr", ram_addr_o, addr_i[w*AW +: AW]);
        chk("mdl_we", ram_we_o, we_i[w]);
        chk("mdl_be", ram_be_o, be_i[w*BW +: BW]);
        chk("mdl_wdata", ram_wdata_o, wdata_i[w*DW +: DW]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = '0;
    lock_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int           wait_cnt [N];
  logic [N-1:0] g;
  logic [N-1:0] exp_lock_seq [3];
  logic [N-1:0] exp_pair [4];
  int           pend0, pend1;

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_gnt", gnt_o, 4'b0000);
    chk("rst_rvalid", rvalid_o, 4'b0000);
    chk("rst_en", ram_en_o, 1'b0);
    step();

    // All ports request continuously from reset.
    do_reset();
    req_i = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("all_gnt", gnt_o, N'(1) << (c % 4));
      if (c > 0) chk("all_rvalid", rvalid_o, N'(1) << ((c - 1) % 4));
      step();
    end
    req_i = '0;

    // Single read on port 2.
    do_reset();
    req_i = 4'b0100;
    addr_i[2*AW +: AW] = 32'h40;
    we_i = '0;
    @(negedge clk);
    chk("rd_gnt", gnt_o, 4'b0100);
    chk("rd_addr", ram_addr_o, 32'h40);
    chk("rd_we", ram_we_o, 1'b0);
    step();
    req_i = '0;
    ram_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_rvalid", rvalid_o, 4'b0100);
    chk("rd_rdata", rdata_o, 32'hDEADBEEF);
    chk("rd_ptr", dut.r_ptr, 2'd3);
    step();

    // Move pointer to 2, then ports 1 and 3 contend.
    req_i = 4'b0010;
    step();
    exp_pair[0] = 4'b1000; exp_pair[1] = 4'b0010;
    exp_pair[2] = 4'b1000; exp_pair[3] = 4'b0010;
    req_i = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("pair_gnt", gnt_o, exp_pair[c]);
      step();
    end

    // Write on port 0.
    req_i = 4'b0001;
    we_i = 4'b0001;
    be_i[0 +: BW] = 4'b0011;
    wdata_i[0 +: DW] = 32'h1234_5678;
    @(negedge clk);
    chk("wr_we", ram_we_o, 1'b1);
    chk("wr_be", ram_be_o, 4'b0011);
    chk("wr_wdata", ram_wdata_o, 32'h1234_5678);
    step();
    req_i = '0;
    we_i = '0;
    @(negedge clk);
    chk("wr_rvalid", rvalid_o, 4'b0001);
    step();

    // Port 1 lock read then unlock write, port 0 requesting throughout (pointer is 1).
`ifdef RAM_ARB_LOCK_EN
    exp_lock_seq[0] = 4'b0010; exp_lock_seq[1] = 4'b0010; exp_lock_seq[2] = 4'b0001;
`else
    exp_lock_seq[0] = 4'b0010; exp_lock_seq[1] = 4'b0001; exp_lock_seq[2] = 4'b0010;
`endif
    pend0 = 1;
    pend1 = 2;
    for (int c = 0; c < 3; c++) begin
      req_i = {2'b00, pend1 > 0, pend0 > 0};
      lock_i = {2'b00, pend1 == 2, 1'b0};
      we_i = {2'b00, pend1 == 1, 1'b0};
      @(negedge clk);
      chk("lock_gnt", gnt_o, exp_lock_seq[c]);
      if (gnt_o[0]) pend0--;
      if (gnt_o[1]) pend1--;
      step();
    end
    req_i = '0;
    lock_i = '0;
    we_i = '0;
    step();

    // Reset right after a grant to port 2 drops the pending response.
    req_i = 4'b0100;
    @(negedge clk);
    chk("rstmid_gnt", gnt_o, 4'b0100);
    #1;
    rst_n = 1'b0;
    req_i = '0;
    step();
    chk("rstmid_rvalid", rvalid_o, 4'b0000);
    chk("rstmid_ptr", dut.r_ptr, 2'd0);
    rst_n = 1'b1;

    // Randomized traffic; requests hold until granted, occasionally dropped.
    do_reset();
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gnt_o;
      for (int k = 0; k < N; k++) begin
        if (req_i[k]) begin
          wait_cnt[k]++;
          if (g[k]) begin
`ifndef RAM_ARB_LOCK_EN
            total++;
            if (wait_cnt[k] > N) begin
              bad++;
              $display("FAIL fairness port %0d: waited %0d cycles, limit %0d", k, wait_cnt[k], N);
            end
`endif
            wait_cnt[k] = 0;
          end
        end else begin
          wait_cnt[k] = 0;
        end
      end
      step();
      for (int k = 0; k < N; k++) begin
        if (req_i[k] && !g[k]) begin
          if ($urandom_range(15) == 0) begin
            req_i[k] = 1'b0;
            wait_cnt[k] = 0;
          end
        end else begin
          req_i[k] = ($urandom_range(1) == 1);
          addr_i[k*AW +: AW] = $urandom;
          we_i[k] = $urandom_range(1) == 1;
          be_i[k*BW +: BW] = BW'($urandom);
          wdata_i[k*DW +: DW] = $urandom;
          lock_i[k] = ($urandom_range(3) == 0);
          wait_cnt[k] = 0;
        end
      end
      ram_rdata_i = $urandom;
    end

    req_i = '0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
